// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the MAC transmit framer.
package mac_pkg;

  localparam int HDR_LEN     = 8;
  localparam int MIN_PAYLOAD = 46;
  localparam int MAX_PAYLOAD = 1500;
  localparam int IFG_CYCLES  = 12;

  typedef enum logic [2:0] {
    S_FILL,
    S_DISCARD,
    S_WAIT_CFG,
    S_SEND,
    S_WAIT_DONE,
    S_IFG
  } framer_state_t;

endpackage

// File: rtl/mac_tx_frame_buf.sv
// Frame buffer: simple dual-port RAM, synchronous write, registered read
// (one-cycle latency), contents not reset.
module mac_tx_frame_buf #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mac_tx_framer.sv
// Buffers one user frame, drops runts/oversize frames, pads to the Ethernet
// minimum and replays it to the MAC transmitter as a contiguous burst.
module mac_tx_framer
  import mac_pkg::*;
#(
  parameter int BUF_DEPTH = 2048,
  parameter int ADDR_W    = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       config_ready,
  output logic [7:0] tx_data,
  output logic       init,
  output logic       frame_end,
  input  logic       frame_over,
  output logic       frame_drop,
  output logic       busy
);

  localparam int                IFG_W     = $clog2(IFG_CYCLES + 1);
  localparam logic [ADDR_W-1:0] HDR_L     = ADDR_W'(HDR_LEN);
  localparam logic [ADDR_W-1:0] MIN_FRAME = ADDR_W'(HDR_LEN + MIN_PAYLOAD);
  localparam logic [ADDR_W-1:0] OVF_CNT   = ADDR_W'(HDR_LEN + MAX_PAYLOAD - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [IFG_W-1:0]  IFG_LOAD  = IFG_W'(IFG_CYCLES - 1);

  framer_state_t     state;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] frame_len;
  logic [ADDR_W-1:0] wr_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [IFG_W-1:0]  ifg_cnt;
  logic              accept;
  logic              wr_en;
  logic [7:0]        rd_data;
  logic              vld_p0;
  logic              first_p0;
  logic              last_p0;
  logic              pad_p0;

  function automatic logic [ADDR_W-1:0] pad_len(input logic [ADDR_W-1:0] n);
    return (n < MIN_FRAME) ? MIN_FRAME : n;
  endfunction

  assign accept  = in_valid & in_ready;
  assign wr_en   = accept & (state == S_FILL);
  assign wr_nxt  = wr_cnt + ONE;
  // Address 0 is presented while leaving S_WAIT_CFG so the burst has no bubble.
  assign rd_addr = (state == S_SEND) ? rd_cnt : '0;

  mac_tx_frame_buf #(
    .DATA_W (8),
    .ADDR_W (ADDR_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_cnt),
    .wr_data (in_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Stage p0: FSM issues buffer reads alongside their framing flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FILL;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      frame_len  <= '0;
      ifg_cnt    <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_drop <= 1'b0;
      vld_p0     <= 1'b0;
      first_p0   <= 1'b0;
      last_p0    <= 1'b0;
      pad_p0     <= 1'b0;
    end else begin
      frame_drop <= 1'b0;
      vld_p0     <= 1'b0;
      first_p0   <= 1'b0;
      last_p0    <= 1'b0;
      case (state)
        S_FILL: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          if (accept) begin
            if (in_last) begin
              if (wr_nxt < HDR_L) begin
                frame_drop <= 1'b1;
                wr_cnt     <= '0;
              end else begin
                frame_len <= pad_len(wr_nxt);
                wr_cnt    <= wr_nxt;
                state     <= S_WAIT_CFG;
                in_ready  <= 1'b0;
                busy      <= 1'b1;
              end
            end else if (wr_cnt == OVF_CNT) begin
              state <= S_DISCARD;
              busy  <= 1'b1;
            end else begin
              wr_cnt <= wr_nxt;
            end
          end
        end
        S_DISCARD: begin
          if (accept && in_last) begin
            frame_drop <= 1'b1;
            wr_cnt     <= '0;
            state      <= S_FILL;
            busy       <= 1'b0;
          end
        end
        S_WAIT_CFG: begin
          if (config_ready) begin
            state    <= S_SEND;
            rd_cnt   <= ONE;
            vld_p0   <= 1'b1;
            first_p0 <= 1'b1;
            pad_p0   <= 1'b0;
          end
        end
        S_SEND: begin
          vld_p0 <= 1'b1;
          pad_p0 <= (rd_cnt >= wr_cnt);
          rd_cnt <= rd_cnt + ONE;
          if (rd_cnt == frame_len - ONE) begin
            last_p0 <= 1'b1;
            state   <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (frame_over) begin
            ifg_cnt <= IFG_LOAD;
            state   <= S_IFG;
          end
        end
        S_IFG: begin
          if (ifg_cnt == '0) begin
            wr_cnt <= '0;
            state  <= S_FILL;
            busy   <= 1'b0;
          end else begin
            ifg_cnt <= ifg_cnt - 1'b1;
          end
        end
        default: begin
          state    <= S_FILL;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Stage p1: RAM data arrives; padding region is forced to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data   <= 8'h00;
      init      <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      tx_data   <= (vld_p0 && !pad_p0) ? rd_data : 8'h00;
      init      <= first_p0;
      frame_end <= last_p0;
    end
  end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Directed bench for mac_tx_framer: loads frames, checks the replayed burst,
// drop handling, config gating, inter-frame gap and reset abort.
module tb_mac_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       config_ready;
  logic [7:0] tx_data;
  logic       init;
  logic       frame_end;
  logic       frame_over;
  logic       frame_drop;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         init_cnt = 0;
  int         end_cnt  = 0;
  int         drop_cnt = 0;
  int         init_cyc = -1;
  int         drop_cyc = -1;
  int         idle_nz  = 0;
  bit         in_frame = 1'b0;
  logic [7:0] rx [$];

  mac_tx_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .config_ready (config_ready),
    .tx_data      (tx_data),
    .init         (init),
    .frame_end    (frame_end),
    .frame_over   (frame_over),
    .frame_drop   (frame_drop),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (init) begin
        in_frame = 1'b1;
        init_cnt++;
        init_cyc = cyc;
        rx.delete();
      end
      if (in_frame) rx.push_back(tx_data);
      else if (tx_data != 8'h00) idle_nz++;
      if (frame_end) begin
        end_cnt++;
        in_frame = 1'b0;
      end
      if (frame_drop) begin
        drop_cnt++;
        drop_cyc = cyc;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input logic [7:0] base, input int i);
    return 8'((int'(base) + i * 13) & 255);
  endfunction

  task automatic send_frame(input int len, input logic [7:0] base, output int a_cyc);
    int n;
    a_cyc = -1;
    for (int i = 0; i < len; i++) begin
      in_data  = pat(base, i);
      in_valid = 1'b1;
      in_last  = (i == len - 1);
      n = 0;
      while (!in_ready && n < 200) begin
        tick();
        n++;
      end
      if (n >= 200) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      tick();
      a_cyc = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_init(input int i0, input string tag);
    int n = 0;
    while (init_cnt == i0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, init_cnt, i0 + 1);
  endtask

  task automatic check_frame(input string tag, input int len, input logic [7:0] base,
                             input int exp_init, input int e0);
    int n = 0;
    int errs = 0;
    int exp_len;
    logic [7:0] exp_b;
    while (end_cnt == e0 && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_end"}, end_cnt, e0 + 1);
    chk({tag, "_init_cyc"}, init_cyc, exp_init);
    exp_len = (len < 54) ? 54 : len;
    chk({tag, "_len"}, rx.size(), exp_len);
    for (int k = 0; k < rx.size(); k++) begin
      exp_b = (k < len) ? pat(base, k) : 8'h00;
      if (rx[k] !== exp_b) errs++;
    end
    chk({tag, "_bad_bytes"}, errs, 0);
  endtask

  task automatic ifg_check(input string tag);
    int f;
    int n = 0;
    repeat (3) tick();
    chk({tag, "_rdy_before"}, in_ready, 1'b0);
    frame_over = 1'b1;
    f = cyc + 1;
    tick();
    frame_over = 1'b0;
    while (!in_ready && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_rdy_cyc"}, cyc, f + 13);
  endtask

  initial begin
    int a, e0, i0, d0, c;
    rst_n        = 1'b0;
    in_data      = 8'h00;
    in_valid     = 1'b0;
    in_last      = 1'b0;
    config_ready = 1'b1;
    frame_over   = 1'b0;

    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_init", init, 1'b0);
    chk("rst_frame_end", frame_end, 1'b0);
    chk("rst_frame_drop", frame_drop, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);

    // 100-byte payload, config already up
    e0 = end_cnt;
    send_frame(108, 8'h11, a);
    check_frame("f108", 108, 8'h11, a + 2, e0);
    ifg_check("f108_ifg");

    // short payload padded to 54
    e0 = end_cnt;
    send_frame(18, 8'h21, a);
    check_frame("f18pad", 18, 8'h21, a + 2, e0);
    ifg_check("f18_ifg");

    // runt
    i0 = init_cnt;
    d0 = drop_cnt;
    send_frame(5, 8'h33, a);
    repeat (10) tick();
    chk("runt_drop_cnt", drop_cnt, d0 + 1);
    chk("runt_drop_cyc", drop_cyc, a);
    chk("runt_no_init", init_cnt, i0);
    chk("runt_in_ready", in_ready, 1'b1);
    e0 = end_cnt;
    send_frame(60, 8'h44, a);
    check_frame("after_runt", 60, 8'h44, a + 2, e0);
    ifg_check("after_runt_ifg");

    // oversize then maximum-length frame
    i0 = init_cnt;
    d0 = drop_cnt;
    send_frame(1600, 8'h55, a);
    repeat (10) tick();
    chk("ovf_drop_cnt", drop_cnt, d0 + 1);
    chk("ovf_drop_cyc", drop_cyc, a);
    chk("ovf_no_init", init_cnt, i0);
    chk("ovf_busy_idle", busy, 1'b0);
    e0 = end_cnt;
    send_frame(1508, 8'h66, a);
    check_frame("max1508", 1508, 8'h66, a + 2, e0);
    ifg_check("max_ifg");

    // config_ready gating, early frame_over and config drop during send
    config_ready = 1'b0;
    e0 = end_cnt;
    i0 = init_cnt;
    send_frame(64, 8'h5A, a);
    repeat (50) tick();
    chk("cfg_hold_no_init", init_cnt, i0);
    chk("cfg_hold_busy", busy, 1'b1);
    config_ready = 1'b1;
    c = cyc;
    wait_init(i0, "cfg_init_seen");
    repeat (10) tick();
    frame_over   = 1'b1;
    config_ready = 1'b0;
    tick();
    frame_over = 1'b0;
    check_frame("cfg", 64, 8'h5A, c + 2, e0);
    config_ready = 1'b1;
    ifg_check("cfg_ifg");

    // reset in the middle of a burst
    e0 = end_cnt;
    i0 = init_cnt;
    send_frame(200, 8'h99, a);
    wait_init(i0, "abort_init_seen");
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("abort_tx_data", tx_data, 8'h00);
    chk("abort_init", init, 1'b0);
    chk("abort_frame_end", frame_end, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_in_ready", in_ready, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("abort_rel_in_ready", in_ready, 1'b1);
    repeat (250) tick();
    chk("abort_no_frame_end", end_cnt, e0);
    e0 = end_cnt;
    send_frame(60, 8'h77, a);
    check_frame("recover", 60, 8'h77, a + 2, e0);
    ifg_check("recover_ifg");

    chk("idle_tx_zero", idle_nz, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
